// File: rtl/ucsbece154b_branch_resolve_if.sv
// Signal bundle between the fetch/decode/execute pipeline and the branch resolve unit.
// The unit sits on the slave side; the pipeline/predictor drives the master side.
interface ucsbece154b_branch_resolve_if #(
   parameter int unsigned NUM_BTB_ENTRIES = 32,
   parameter int unsigned NUM_GHR_BITS    = 5
);
   localparam int unsigned IDX = $clog2(NUM_BTB_ENTRIES);

   logic [31:0]             pc_f_i;
   logic                    BranchTaken_f_i;
   logic [31:0]             BTBtarget_f_i;
   logic [NUM_GHR_BITS-1:0] PHTindex_f_i;
   logic                    stall_d_i;
   logic                    flush_d_i;
   logic                    flush_e_i;
   logic [6:0]              op_e_i;
   logic                    cond_e_i;
   logic [31:0]             target_e_i;

   logic                    Mispredict_o;
   logic [31:0]             PCcorrect_o;
   logic                    BTB_we_o;
   logic [IDX-1:0]          BTBwriteaddress_o;
   logic [31:0]             BTBwritedata_o;
   logic                    PHTwe_o;
   logic                    PHTincrement_o;
   logic [NUM_GHR_BITS-1:0] PHTwriteaddress_o;
   logic                    GHRreset_o;
   logic [31:0]             branch_count_o;
   logic [31:0]             mispredict_count_o;

   modport slave (
      input  pc_f_i, BranchTaken_f_i, BTBtarget_f_i, PHTindex_f_i,
      input  stall_d_i, flush_d_i, flush_e_i, op_e_i, cond_e_i, target_e_i,
      output Mispredict_o, PCcorrect_o, BTB_we_o, BTBwriteaddress_o, BTBwritedata_o,
      output PHTwe_o, PHTincrement_o, PHTwriteaddress_o, GHRreset_o,
      output branch_count_o, mispredict_count_o
   );

   modport master (
      output pc_f_i, BranchTaken_f_i, BTBtarget_f_i, PHTindex_f_i,
      output stall_d_i, flush_d_i, flush_e_i, op_e_i, cond_e_i, target_e_i,
      input  Mispredict_o, PCcorrect_o, BTB_we_o, BTBwriteaddress_o, BTBwritedata_o,
      input  PHTwe_o, PHTincrement_o, PHTwriteaddress_o, GHRreset_o,
      input  branch_count_o, mispredict_count_o
   );
endinterface

// File: rtl/ucsbece154b_branch_resolve.sv
// Execute-stage branch resolution: carries prediction metadata F->D->E, detects
// mispredictions, and produces predictor update strobes and statistics counters.
module ucsbece154b_branch_resolve #(
   parameter int unsigned NUM_BTB_ENTRIES = 32,
   parameter int unsigned NUM_GHR_BITS    = 5
) (
   input logic                          clk,
   input logic                          reset_i,
   ucsbece154b_branch_resolve_if.slave  bus
);
   localparam int unsigned IDX = $clog2(NUM_BTB_ENTRIES);

   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;

   typedef struct packed {
      logic                    valid;
      logic [31:0]             pc;
      logic                    pred_taken;
      logic [31:0]             pred_target;
      logic [NUM_GHR_BITS-1:0] pht_idx;
   } meta_t;

   meta_t       d_q, d_d, e_q, e_d;
   logic        armed_q;
   logic [31:0] branch_cnt_q, mispred_cnt_q;

   logic is_branch, is_jal, is_jalr, is_ctrl;
   logic actual_taken, tgt_mismatch, mispredict;

   // Every decode term is qualified by E.valid so a flushed slot never resolves.
   always_comb begin
      is_branch    = e_q.valid & (bus.op_e_i == OpBranch);
      is_jal       = e_q.valid & (bus.op_e_i == OpJal);
      is_jalr      = e_q.valid & (bus.op_e_i == OpJalr);
      is_ctrl      = is_branch | is_jal | is_jalr;
      actual_taken = is_jal | is_jalr | (is_branch & bus.cond_e_i);
      tgt_mismatch = (e_q.pred_target != bus.target_e_i);
      mispredict   = e_q.valid & ((e_q.pred_taken != actual_taken) |
                                  (actual_taken & tgt_mismatch));
   end

   assign bus.Mispredict_o      = mispredict;
   assign bus.PCcorrect_o       = !mispredict   ? 32'd0 :
                                  actual_taken  ? bus.target_e_i : (e_q.pc + 32'd4);
   assign bus.BTB_we_o          = is_ctrl & actual_taken & (~e_q.pred_taken | tgt_mismatch);
   assign bus.BTBwriteaddress_o = e_q.pc[IDX+1:2];
   assign bus.BTBwritedata_o    = bus.target_e_i;
   assign bus.PHTwe_o           = is_branch;
   assign bus.PHTincrement_o    = is_branch & bus.cond_e_i;
   assign bus.PHTwriteaddress_o = e_q.pht_idx;
   assign bus.GHRreset_o        = armed_q;
   assign bus.branch_count_o    = branch_cnt_q;
   assign bus.mispredict_count_o = mispred_cnt_q;

   // A redirect kills D even when decode is stalled.
   always_comb begin
      d_d = d_q;
      if (bus.flush_d_i | mispredict) begin
         d_d.valid = 1'b0;
      end else if (!bus.stall_d_i) begin
         d_d.valid       = 1'b1;
         d_d.pc          = bus.pc_f_i;
         d_d.pred_taken  = bus.BranchTaken_f_i;
         d_d.pred_target = bus.BTBtarget_f_i;
         d_d.pht_idx     = bus.PHTindex_f_i;
      end
      e_d = d_q;
      if (bus.flush_e_i | mispredict) begin
         e_d.valid = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_i) begin
      if (!reset_i) begin
         d_q           <= '0;
         e_q           <= '0;
         armed_q       <= 1'b1;
         branch_cnt_q  <= 32'd0;
         mispred_cnt_q <= 32'd0;
      end else begin
         d_q     <= d_d;
         e_q     <= e_d;
         armed_q <= 1'b0;
         if (is_ctrl)    branch_cnt_q  <= branch_cnt_q + 32'd1;
         if (mispredict) mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
   end
endmodule

// File: tb/tb_ucsbece154b_branch_resolve.sv
// Directed-vector bench for ucsbece154b_branch_resolve.
module tb_ucsbece154b_branch_resolve;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_ALU  = 7'b0010011;

   logic clk = 1'b0;
   logic reset_i = 1'b0;
   int   n_cmp = 0;
   int   n_fail = 0;
   logic [31:0] exp_bc = 0;
   logic [31:0] exp_mc = 0;

   ucsbece154b_branch_resolve_if #(.NUM_BTB_ENTRIES(32), .NUM_GHR_BITS(5)) bus ();

   ucsbece154b_branch_resolve #(.NUM_BTB_ENTRIES(32), .NUM_GHR_BITS(5)) dut (
      .clk     (clk),
      .reset_i (reset_i),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                        input logic [4:0] idx);
      bus.pc_f_i = pc; bus.BranchTaken_f_i = tk; bus.BTBtarget_f_i = tgt;
      bus.PHTindex_f_i = idx;
   endtask

   task automatic exec(input logic [6:0] op, input logic cond, input logic [31:0] tgt);
      bus.op_e_i = op; bus.cond_e_i = cond; bus.target_e_i = tgt;
   endtask

   task automatic test_reset();
      fetch(32'h0, 1'b0, 32'h0, 5'h0);
      exec(7'h0, 1'b0, 32'h0);
      bus.stall_d_i = 1'b0; bus.flush_d_i = 1'b0; bus.flush_e_i = 1'b0;
      reset_i = 1'b0;
      tick(); tick();
      reset_i = 1'b1;
      #1;
      n_cmp++; if (bus.GHRreset_o !== 1'b1) begin n_fail++;
         $display("FAIL rst_ghr_pulse got %b want 1", bus.GHRreset_o); end
      n_cmp++; if (bus.branch_count_o !== 32'd0) begin n_fail++;
         $display("FAIL rst_bcount got %h want 0", bus.branch_count_o); end
      n_cmp++; if (bus.mispredict_count_o !== 32'd0) begin n_fail++;
         $display("FAIL rst_mcount got %h want 0", bus.mispredict_count_o); end
      n_cmp++; if ({bus.Mispredict_o, bus.BTB_we_o, bus.PHTwe_o} !== 3'b000) begin n_fail++;
         $display("FAIL rst_strobes got %b want 000",
                  {bus.Mispredict_o, bus.BTB_we_o, bus.PHTwe_o}); end
      tick();
      n_cmp++; if (bus.GHRreset_o !== 1'b0) begin n_fail++;
         $display("FAIL rst_ghr_clear got %b want 0", bus.GHRreset_o); end
   endtask

   task automatic test_correct_branch();
      fetch(32'h40, 1'b1, 32'h20, 5'h0A); tick();
      fetch(32'h1000, 1'b0, 32'h0, 5'h0); tick();
      exec(OP_BR, 1'b1, 32'h20); #1;
      n_cmp++; if (bus.Mispredict_o !== 1'b0) begin n_fail++;
         $display("FAIL cb_mispredict got %b want 0", bus.Mispredict_o); end
      n_cmp++; if ({bus.PHTwe_o, bus.PHTincrement_o, bus.BTB_we_o} !== 3'b110) begin n_fail++;
         $display("FAIL cb_strobes got %b want 110",
                  {bus.PHTwe_o, bus.PHTincrement_o, bus.BTB_we_o}); end
      n_cmp++; if (bus.PHTwriteaddress_o !== 5'h0A) begin n_fail++;
         $display("FAIL cb_phtaddr got %h want 0a", bus.PHTwriteaddress_o); end
      n_cmp++; if (bus.BTBwriteaddress_o !== 5'h10) begin n_fail++;
         $display("FAIL cb_btbaddr got %h want 10", bus.BTBwriteaddress_o); end
      tick(); exec(7'h0, 1'b0, 32'h0);
      exp_bc++;
      n_cmp++; if (bus.branch_count_o !== exp_bc) begin n_fail++;
         $display("FAIL cb_bcount got %h want %h", bus.branch_count_o, exp_bc); end
   endtask

   task automatic test_mispredict_not_taken();
      fetch(32'h44, 1'b1, 32'h60, 5'h03); tick();
      fetch(32'h1000, 1'b0, 32'h0, 5'h0); tick();
      exec(OP_BR, 1'b0, 32'h60); #1;
      n_cmp++; if (bus.Mispredict_o !== 1'b1) begin n_fail++;
         $display("FAIL mnt_mispredict got %b want 1", bus.Mispredict_o); end
      n_cmp++; if (bus.PCcorrect_o !== 32'h48) begin n_fail++;
         $display("FAIL mnt_pccorrect got %h want 00000048", bus.PCcorrect_o); end
      n_cmp++; if ({bus.PHTwe_o, bus.PHTincrement_o, bus.BTB_we_o} !== 3'b100) begin n_fail++;
         $display("FAIL mnt_strobes got %b want 100",
                  {bus.PHTwe_o, bus.PHTincrement_o, bus.BTB_we_o}); end
      tick();
      exp_bc++; exp_mc++;
      // E is flushed: a branch opcode here must not resolve
      exec(OP_BR, 1'b1, 32'h0); #1;
      n_cmp++; if ({bus.Mispredict_o, bus.PHTwe_o, bus.PCcorrect_o} !== 34'd0) begin n_fail++;
         $display("FAIL mnt_bubble1 got %b%b %h want 0 0 0",
                  bus.Mispredict_o, bus.PHTwe_o, bus.PCcorrect_o); end
      n_cmp++; if (bus.mispredict_count_o !== exp_mc) begin n_fail++;
         $display("FAIL mnt_mcount got %h want %h", bus.mispredict_count_o, exp_mc); end
      n_cmp++; if (bus.branch_count_o !== exp_bc) begin n_fail++;
         $display("FAIL mnt_bcount got %h want %h", bus.branch_count_o, exp_bc); end
      tick();
      n_cmp++; if ({bus.Mispredict_o, bus.PHTwe_o} !== 2'b00) begin n_fail++;
         $display("FAIL mnt_bubble2 got %b want 00", {bus.Mispredict_o, bus.PHTwe_o}); end
      exec(7'h0, 1'b0, 32'h0);
   endtask

   task automatic test_first_jal();
      fetch(32'h80, 1'b0, 32'h0, 5'h07); tick();
      fetch(32'h1000, 1'b0, 32'h0, 5'h0); tick();
      exec(OP_JAL, 1'b0, 32'h100); #1;
      n_cmp++; if (bus.Mispredict_o !== 1'b1) begin n_fail++;
         $display("FAIL jal_mispredict got %b want 1", bus.Mispredict_o); end
      n_cmp++; if (bus.PCcorrect_o !== 32'h100) begin n_fail++;
         $display("FAIL jal_pccorrect got %h want 00000100", bus.PCcorrect_o); end
      n_cmp++; if ({bus.BTB_we_o, bus.PHTwe_o} !== 2'b10) begin n_fail++;
         $display("FAIL jal_strobes got %b want 10", {bus.BTB_we_o, bus.PHTwe_o}); end
      n_cmp++; if ({bus.BTBwriteaddress_o, bus.BTBwritedata_o} !== {5'h00, 32'h100}) begin
         n_fail++; $display("FAIL jal_btbwrite got %h/%h want 00/00000100",
                            bus.BTBwriteaddress_o, bus.BTBwritedata_o); end
      tick(); exec(7'h0, 1'b0, 32'h0);
      exp_bc++; exp_mc++;
   endtask

   task automatic test_alias();
      fetch(32'h90, 1'b1, 32'h200, 5'h04); tick();
      fetch(32'h1000, 1'b0, 32'h0, 5'h0); tick();
      exec(OP_ALU, 1'b1, 32'h200); #1;
      n_cmp++; if ({bus.Mispredict_o, bus.BTB_we_o, bus.PHTwe_o, bus.PHTincrement_o} !== 4'b1000)
      begin n_fail++; $display("FAIL alias_strobes got %b want 1000",
         {bus.Mispredict_o, bus.BTB_we_o, bus.PHTwe_o, bus.PHTincrement_o}); end
      n_cmp++; if (bus.PCcorrect_o !== 32'h94) begin n_fail++;
         $display("FAIL alias_pccorrect got %h want 00000094", bus.PCcorrect_o); end
      tick(); exec(7'h0, 1'b0, 32'h0);
      exp_mc++;
      n_cmp++; if ({bus.branch_count_o, bus.mispredict_count_o} !== {exp_bc, exp_mc}) begin
         n_fail++; $display("FAIL alias_counts got %h/%h want %h/%h",
            bus.branch_count_o, bus.mispredict_count_o, exp_bc, exp_mc); end
   endtask

   task automatic test_back_to_back();
      fetch(32'h100, 1'b1, 32'h300, 5'h02); tick();
      fetch(32'h104, 1'b1, 32'h180, 5'h1F); tick();
      fetch(32'h1000, 1'b0, 32'h0, 5'h0);
      exec(OP_JALR, 1'b0, 32'h300); #1;
      n_cmp++; if ({bus.Mispredict_o, bus.BTB_we_o, bus.PHTwe_o, bus.PHTincrement_o} !== 4'b0000)
      begin n_fail++; $display("FAIL b2b_jalr got %b want 0000",
         {bus.Mispredict_o, bus.BTB_we_o, bus.PHTwe_o, bus.PHTincrement_o}); end
      tick();
      exec(OP_BR, 1'b1, 32'h180); #1;
      n_cmp++; if ({bus.Mispredict_o, bus.BTB_we_o, bus.PHTwe_o, bus.PHTincrement_o} !== 4'b0011)
      begin n_fail++; $display("FAIL b2b_branch got %b want 0011",
         {bus.Mispredict_o, bus.BTB_we_o, bus.PHTwe_o, bus.PHTincrement_o}); end
      n_cmp++; if ({bus.PHTwriteaddress_o, bus.BTBwriteaddress_o} !== {5'h1F, 5'h01}) begin
         n_fail++; $display("FAIL b2b_addrs got %h/%h want 1f/01",
                            bus.PHTwriteaddress_o, bus.BTBwriteaddress_o); end
      tick(); exec(7'h0, 1'b0, 32'h0);
      exp_bc += 2;
      n_cmp++; if (bus.branch_count_o !== exp_bc) begin n_fail++;
         $display("FAIL b2b_bcount got %h want %h", bus.branch_count_o, exp_bc); end
   endtask

   task automatic test_stall();
      fetch(32'hC0, 1'b1, 32'h10, 5'h15); tick();
      fetch(32'h1000, 1'b0, 32'h0, 5'h0);
      bus.stall_d_i = 1'b1; bus.flush_e_i = 1'b1;
      tick();
      for (int i = 0; i < 2; i++) begin
         exec(OP_BR, 1'b1, 32'h10); #1;
         n_cmp++; if ({bus.Mispredict_o, bus.PHTwe_o, bus.BTB_we_o} !== 3'b000) begin n_fail++;
            $display("FAIL stall_bubble%0d got %b want 000", i,
                     {bus.Mispredict_o, bus.PHTwe_o, bus.BTB_we_o}); end
         if (i == 1) begin bus.stall_d_i = 1'b0; bus.flush_e_i = 1'b0; end
         exec(7'h0, 1'b0, 32'h0);
         tick();
      end
      exec(OP_BR, 1'b1, 32'h10); #1;
      n_cmp++; if ({bus.Mispredict_o, bus.PHTwe_o, bus.PHTincrement_o} !== 3'b011) begin
         n_fail++; $display("FAIL stall_resolve got %b want 011",
                            {bus.Mispredict_o, bus.PHTwe_o, bus.PHTincrement_o}); end
      n_cmp++; if (bus.PHTwriteaddress_o !== 5'h15) begin n_fail++;
         $display("FAIL stall_phtaddr got %h want 15", bus.PHTwriteaddress_o); end
      tick(); exec(7'h0, 1'b0, 32'h0);
      exp_bc++;
   endtask

   task automatic test_flush_vs_stall();
      fetch(32'hD0, 1'b1, 32'h50, 5'h05); tick();
      fetch(32'hD4, 1'b1, 32'h70, 5'h06); tick();
      fetch(32'h1000, 1'b0, 32'h0, 5'h0);
      bus.stall_d_i = 1'b1;
      exec(OP_BR, 1'b0, 32'h50); #1;
      n_cmp++; if ({bus.Mispredict_o, bus.PCcorrect_o} !== {1'b1, 32'hD4}) begin n_fail++;
         $display("FAIL fvs_redirect got %b/%h want 1/000000d4",
                  bus.Mispredict_o, bus.PCcorrect_o); end
      tick();
      bus.stall_d_i = 1'b0;
      exec(OP_ALU, 1'b0, 32'h0);
      tick(); #1;
      // A held D (0xD4, predicted taken) would alias-mispredict here
      n_cmp++; if (bus.Mispredict_o !== 1'b0) begin n_fail++;
         $display("FAIL fvs_dkilled got %b want 0", bus.Mispredict_o); end
      exec(7'h0, 1'b0, 32'h0);
      exp_bc++; exp_mc++;
      n_cmp++; if ({bus.branch_count_o, bus.mispredict_count_o} !== {exp_bc, exp_mc}) begin
         n_fail++; $display("FAIL fvs_counts got %h/%h want %h/%h",
            bus.branch_count_o, bus.mispredict_count_o, exp_bc, exp_mc); end
   endtask

   task automatic test_counter_wrap();
      fetch(32'hE0, 1'b0, 32'h0, 5'h01); tick();
      fetch(32'h1000, 1'b0, 32'h0, 5'h0); tick();
      exec(OP_BR, 1'b0, 32'h0); #1;
      n_cmp++; if ({bus.Mispredict_o, bus.PHTwe_o, bus.PHTincrement_o, bus.BTB_we_o} !== 4'b0100)
      begin n_fail++; $display("FAIL wrap_nt_strobes got %b want 0100",
         {bus.Mispredict_o, bus.PHTwe_o, bus.PHTincrement_o, bus.BTB_we_o}); end
      force dut.branch_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.branch_cnt_q;
      #1;
      n_cmp++; if (bus.branch_count_o !== 32'hFFFF_FFFF) begin n_fail++;
         $display("FAIL wrap_preload got %h want ffffffff", bus.branch_count_o); end
      tick(); exec(7'h0, 1'b0, 32'h0);
      exp_bc = 32'd0;
      n_cmp++; if ({bus.branch_count_o, bus.mispredict_count_o} !== {exp_bc, exp_mc}) begin
         n_fail++; $display("FAIL wrap_counts got %h/%h want %h/%h",
            bus.branch_count_o, bus.mispredict_count_o, exp_bc, exp_mc); end
   endtask

   task automatic test_reset_mid();
      fetch(32'hF0, 1'b1, 32'h40, 5'h09); tick();
      fetch(32'h1000, 1'b0, 32'h0, 5'h0); tick();
      exec(OP_BR, 1'b1, 32'h40);
      reset_i = 1'b0; #1;
      n_cmp++; if ({bus.Mispredict_o, bus.PHTwe_o, bus.BTB_we_o} !== 3'b000) begin n_fail++;
         $display("FAIL rmid_strobes got %b want 000",
                  {bus.Mispredict_o, bus.PHTwe_o, bus.BTB_we_o}); end
      n_cmp++; if ({bus.branch_count_o, bus.mispredict_count_o} !== 64'd0) begin n_fail++;
         $display("FAIL rmid_counts got %h/%h want 0/0",
                  bus.branch_count_o, bus.mispredict_count_o); end
      tick();
      reset_i = 1'b1; #1;
      n_cmp++; if (bus.GHRreset_o !== 1'b1) begin n_fail++;
         $display("FAIL rmid_ghr got %b want 1", bus.GHRreset_o); end
      tick();
      n_cmp++; if ({bus.GHRreset_o, bus.PHTwe_o, bus.Mispredict_o} !== 3'b000) begin n_fail++;
         $display("FAIL rmid_after got %b want 000",
                  {bus.GHRreset_o, bus.PHTwe_o, bus.Mispredict_o}); end
      exec(7'h0, 1'b0, 32'h0);
   endtask

   initial begin
      test_reset();
      test_correct_branch();
      test_mispredict_not_taken();
      test_first_jal();
      test_alias();
      test_back_to_back();
      test_stall();
      test_flush_vs_stall();
      test_counter_wrap();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
